// File: rtl/vector_fp_result_writeback_pkg.sv
// Shared vector sizing plus the writeback entry and tracking types
// used by the FP conversion writeback stage.
package vector_fp_result_writeback_pkg;

    localparam int VLEN    = 128;
    localparam int ELEN    = 32;
    localparam int ADDR_W  = 5;
    localparam int LANES   = VLEN / ELEN;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] vd_addr;
        logic [VLEN-1:0]   data;
        logic [LANES-1:0]  be;
    } writeback_entry_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] vd_addr;
        logic              vm;
        logic [LANES-1:0]  v0;
        logic [VLEN-1:0]   vd_old;
    } track_t;

    // Masked-off elements keep the old destination contents.
    function automatic writeback_entry_t merge_result(
        input logic [ADDR_W-1:0] addr,
        input logic              vm,
        input logic [LANES-1:0]  v0,
        input logic [VLEN-1:0]   old,
        input logic [VLEN-1:0]   res
    );
        writeback_entry_t e;
        e.vd_addr = addr;
        e.be      = '0;
        e.data    = '0;
        for (int i = 0; i < LANES; i++) begin
            e.be[i] = vm | v0[i];
            e.data[i*ELEN +: ELEN] = e.be[i]
                ? res[i*ELEN +: ELEN]
                : old[i*ELEN +: ELEN];
        end
        return e;
    endfunction

endpackage

// File: rtl/vector_result_fifo.sv
// Small result FIFO with a registered head; pointers carry a wrap bit.
// DEPTH must be a power of two and at least 2.
module vector_result_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [7:0]
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  entry_t                 din,
    input  logic                   pop,
    output entry_t                 dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    entry_t        mem_q [DEPTH];
    entry_t        head_q;
    entry_t        head_d;
    logic [AW:0]   wr_q;
    logic [AW:0]   rd_q;
    logic [AW:0]   wr_d;
    logic [AW:0]   rd_d;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW])
                  && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count   = wr_q - rd_q;
    assign do_push = push && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = head_q;

    // Next pointers and next head, bypassing a push into the head slot
    always_comb begin
        wr_d   = wr_q + {{AW{1'b0}}, do_push};
        rd_d   = rd_q + {{AW{1'b0}}, do_pop};
        head_d = head_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else if (wr_d != rd_d) begin
            if (do_push && (rd_d[AW-1:0] == wr_q[AW-1:0]))
                head_d = din;
            else
                head_d = mem_q[rd_d[AW-1:0]];
        end
    end

    // Pointer and head register state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            head_q <= head_d;
        end
    end

    // Entry storage; contents are only meaningful between the pointers
    always_ff @(posedge clock) begin
        if (do_push)
            mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/vector_fp_result_writeback.sv
// Tracks conversions through the fixed-latency FP unit, merges v0-masked
// elements and buffers results for the vector register file.
module vector_fp_result_writeback
    import vector_fp_result_writeback_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] issue_vd_addr,
    input  logic              issue_vm,
    input  logic [LANES-1:0]  issue_v0,
    input  logic [VLEN-1:0]   issue_vd_old,
    input  logic [VLEN-1:0]   vd_result,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_vd_addr,
    output logic [VLEN-1:0]   wb_data,
    output logic [LANES-1:0]  wb_be
);
    localparam logic [CNT_W:0] DEPTH_U = DEPTH;

    track_t            trk_q [LATENCY];
    track_t            trk_in;
    track_t            trk_out;
    writeback_entry_t  merged;
    writeback_entry_t  head;
    logic              accept;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  inflight_q;
    logic [CNT_W:0]    used;

    assign used        = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign issue_ready = !reset && !flush && (used < DEPTH_U);
    assign accept      = issue_valid && issue_ready;
    assign trk_out     = trk_q[LATENCY-1];
    assign push        = trk_out.valid;
    assign pop         = wb_valid && wb_ready;

    // Sideband captured alongside each accepted conversion
    always_comb begin
        trk_in         = '0;
        trk_in.valid   = accept;
        trk_in.vd_addr = issue_vd_addr;
        trk_in.vm      = issue_vm;
        trk_in.v0      = issue_v0;
        trk_in.vd_old  = issue_vd_old;
    end

    // Tracking pipeline advances every cycle, mirroring the unit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++)
                trk_q[i] <= '0;
        end else begin
            trk_q[0] <= trk_in;
            for (int i = 1; i < LATENCY; i++)
                trk_q[i] <= trk_q[i-1];
            if (flush) begin
                for (int i = 0; i < LATENCY; i++)
                    trk_q[i].valid <= 1'b0;
            end
        end
    end

    // In-flight credits: taken on accept, handed to the FIFO on push
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            inflight_q <= '0;
        else if (flush)
            inflight_q <= '0;
        else
            inflight_q <= inflight_q
                        + {{(CNT_W-1){1'b0}}, accept}
                        - {{(CNT_W-1){1'b0}}, push};
    end

    assign merged = merge_result(
        trk_out.vd_addr,
        trk_out.vm,
        trk_out.v0,
        trk_out.vd_old,
        vd_result
    );

    vector_result_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (writeback_entry_t)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .din   (merged),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign wb_valid   = !fifo_empty;
    assign wb_vd_addr = head.vd_addr;
    assign wb_data    = head.data;
    assign wb_be      = head.be;

    a_no_overflow: assert property (
        @(posedge clock) disable iff (reset)
        !(push && fifo_full)
    );

    a_credit: assert property (
        @(posedge clock) disable iff (reset)
        used <= DEPTH_U
    );

endmodule

// File: tb/tb_vector_fp_result_writeback.sv
// Scoreboard bench for vector_fp_result_writeback: directed issues with
// hand-computed and modelled expectations, popped by a separate monitor.
module tb_vector_fp_result_writeback;
    import vector_fp_result_writeback_pkg::*;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              flush = 1'b0;
    logic              issue_valid = 1'b0;
    logic              issue_ready;
    logic [ADDR_W-1:0] issue_vd_addr = '0;
    logic              issue_vm = 1'b0;
    logic [LANES-1:0]  issue_v0 = '0;
    logic [VLEN-1:0]   issue_vd_old = '0;
    logic [VLEN-1:0]   vd_result;
    logic              wb_valid;
    logic              wb_ready = 1'b0;
    logic [ADDR_W-1:0] wb_vd_addr;
    logic [VLEN-1:0]   wb_data;
    logic [LANES-1:0]  wb_be;

    logic [VLEN-1:0]   issue_res = '0;
    logic [VLEN-1:0]   res_p0 = '0;
    logic [VLEN-1:0]   res_p1 = '0;

    writeback_entry_t  exp_q[$];
    int n_chk = 0;
    int n_pass = 0;
    int n_acc = 0;
    int n_pop = 0;
    int max_out = 0;

    vector_fp_result_writeback dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_vd_addr (issue_vd_addr),
        .issue_vm      (issue_vm),
        .issue_v0      (issue_v0),
        .issue_vd_old  (issue_vd_old),
        .vd_result     (vd_result),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_vd_addr    (wb_vd_addr),
        .wb_data       (wb_data),
        .wb_be         (wb_be)
    );

    always #5 clock = ~clock;

    // Conversion unit stand-in: result appears two cycles after issue
    always @(posedge clock) begin
        res_p0 <= issue_res;
        res_p1 <= res_p0;
    end
    assign vd_result = res_p1;

    function automatic void chk(string nm, logic [127:0] act,
                                logic [127:0] expv);
        n_chk++;
        if (act === expv)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", nm, act, expv);
    endfunction

    function automatic writeback_entry_t mk(logic [4:0] a,
                                            logic [127:0] d,
                                            logic [3:0] be);
        writeback_entry_t e;
        e.vd_addr = a;
        e.data    = d;
        e.be      = be;
        return e;
    endfunction

    function automatic writeback_entry_t model(logic [4:0] a, logic m,
                                               logic [3:0] z,
                                               logic [127:0] old,
                                               logic [127:0] res);
        logic [3:0]   be;
        logic [127:0] msk;
        be  = m ? 4'hF : z;
        msk = {{32{be[3]}}, {32{be[2]}}, {32{be[1]}}, {32{be[0]}}};
        return mk(a, (res & msk) | (old & ~msk), be);
    endfunction

    // One issue cycle; an accepted issue queues its expected result
    task automatic drive(input logic v, input logic [4:0] a,
                         input logic m, input logic [3:0] z,
                         input logic [127:0] old,
                         input logic [127:0] res,
                         input bit use_exp,
                         input writeback_entry_t e,
                         output bit acc);
        issue_valid   = v;
        issue_vd_addr = a;
        issue_vm      = m;
        issue_v0      = z;
        issue_vd_old  = old;
        issue_res     = res;
        @(negedge clock);
        acc = v && issue_ready;
        if (acc) begin
            exp_q.push_back(use_exp ? e : model(a, m, z, old, res));
            n_acc++;
        end
        @(posedge clock);
        #1;
        issue_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        wb_ready = 1'b1;
        for (int c = 0; c < 30 && exp_q.size() != 0; c++)
            @(posedge clock);
        #1;
        chk(nm, exp_q.size(), 0);
    endtask

    // Monitor: compare every handshaken result against the queue head
    always @(negedge clock) begin
        writeback_entry_t e;
        if (!reset) begin
            if (n_acc - n_pop > max_out)
                max_out = n_acc - n_pop;
            if (wb_valid && wb_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL wb_unexpected: got addr %0d, none expected",
                             wb_vd_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_vd_addr", wb_vd_addr, e.vd_addr);
                    chk("wb_data", wb_data, e.data);
                    chk("wb_be", wb_be, e.be);
                end
                n_pop++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        int cnt;
        int got;
        int pop0;
        int late;
        writeback_entry_t none;
        none = '0;

        #2 reset = 1'b1;
        #1;
        chk("rst_issue_ready", issue_ready, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_vd_addr", wb_vd_addr, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_be", wb_be, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;

        // Unmasked single issue, latency 3
        wb_ready = 1'b1;
        drive(1, 5'd5, 1, 4'h0, '0, {16{8'hA5}}, 1,
              mk(5'd5, {16{8'hA5}}, 4'hF), acc);
        chk("t1_accept", acc, 1);
        @(negedge clock) chk("t1_lat1_low", wb_valid, 0);
        @(negedge clock) chk("t1_lat2_low", wb_valid, 0);
        @(negedge clock) chk("t1_lat3_high", wb_valid, 1);
        @(posedge clock);
        #1;

        // Masked issue
        drive(1, 5'd9, 0, 4'b0101, {128{1'b1}}, '0, 1,
              mk(5'd9, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000, 4'h5),
              acc);
        drain("t2_drained");

        // Back-pressure: credits stop issue after four
        wb_ready = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1, 5'(k + 1), (k % 2 == 1), 4'(k),
                  {4{32'hCAFE0000 + 32'(k)}}, {4{32'h00001000 + 32'(k)}},
                  0, none, acc);
            cnt += int'(acc);
        end
        chk("bp_accepts", cnt, 4);
        @(negedge clock);
        chk("bp_ready_low", issue_ready, 0);
        chk("bp_head_valid", wb_valid, 1);
        @(posedge clock);
        #1 wb_ready = 1'b1;
        @(posedge clock);
        #1 wb_ready = 1'b0;
        @(negedge clock) chk("bp_ready_reraise", issue_ready, 1);
        @(posedge clock);
        #1;
        drain("bp_drained");

        // Back-to-back stream with a stuttering register file
        max_out = 0;
        pop0 = n_pop;
        got = 0;
        for (int c = 0; c < 60 && got < 10; c++) begin
            wb_ready = (c % 3 != 2);
            drive(1, 5'(got + 10), (got % 2 == 0), 4'(got * 3),
                  {4{32'h5A5A0000 | 32'(got)}},
                  {4{32'h00C0FFEE ^ 32'(got * 7)}}, 0, none, acc);
            got += int'(acc);
        end
        chk("stream_accepts", got, 10);
        drain("stream_drained");
        chk("stream_popped", n_pop - pop0, 10);
        chk("stream_max_out_le4", max_out <= 4, 1);

        // Flush with two in flight and two buffered
        wb_ready = 1'b0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            drive(1, 5'(20 + k), 1, 4'h0, '0, {4{32'(k)}}, 0, none, acc);
            cnt += int'(acc);
        end
        chk("fl_accepts", cnt, 4);
        flush = 1'b1;
        @(negedge clock);
        chk("fl_ready_low", issue_ready, 0);
        chk("fl_valid_before", wb_valid, 1);
        @(posedge clock);
        #1 flush = 1'b0;
        exp_q.delete();
        n_acc = n_pop;
        @(negedge clock);
        chk("fl_valid_after", wb_valid, 0);
        chk("fl_ready_after", issue_ready, 1);
        @(posedge clock);
        #1 wb_ready = 1'b1;
        late = 0;
        repeat (6) @(negedge clock) if (wb_valid) late++;
        chk("fl_no_late", late, 0);
        @(posedge clock);
        #1;

        // Asynchronous reset between edges mid-stream
        wb_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            drive(1, 5'(28 + k), 0, 4'h3, {128{1'b1}}, '0, 0, none, acc);
        @(negedge clock) chk("rs_valid_before", wb_valid, 1);
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        chk("rs_wb_valid", wb_valid, 0);
        chk("rs_wb_vd_addr", wb_vd_addr, 0);
        chk("rs_wb_data", wb_data, 0);
        chk("rs_wb_be", wb_be, 0);
        chk("rs_issue_ready", issue_ready, 0);
        exp_q.delete();
        n_acc = n_pop;
        @(negedge clock);
        #2 reset = 1'b0;
        @(posedge clock);
        #1 wb_ready = 1'b1;
        drive(1, 5'd7, 0, 4'b1010,
              {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444},
              {32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD}, 1,
              mk(5'd7, 128'hAAAAAAAA_22222222_CCCCCCCC_44444444, 4'hA),
              acc);
        chk("rs_post_accept", acc, 1);
        @(negedge clock) chk("rs_lat1_low", wb_valid, 0);
        @(negedge clock) chk("rs_lat2_low", wb_valid, 0);
        @(negedge clock) chk("rs_lat3_high", wb_valid, 1);
        @(posedge clock);
        #1;
        drain("final_queue_empty");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
